// File: rtl/proc_ctrl_pkg.sv
// Shared encodings for the accumulator processor control path: opcodes,
// controller state encoding, ALU operation select and opcode decode helpers.
package proc_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_MEM    = 3'd3,
    ST_HALT   = 3'd4
  } state_t;

  typedef enum logic [2:0] {
    ALU_PASS = 3'd0,
    ALU_ADD  = 3'd1,
    ALU_SUB  = 3'd2,
    ALU_AND  = 3'd3,
    ALU_OR   = 3'd4
  } alu_op_t;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_STA = 4'h2;
  localparam logic [3:0] OP_ADD = 4'h3;
  localparam logic [3:0] OP_SUB = 4'h4;
  localparam logic [3:0] OP_AND = 4'h5;
  localparam logic [3:0] OP_OR  = 4'h6;
  localparam logic [3:0] OP_JMP = 4'h7;
  localparam logic [3:0] OP_JZ  = 4'h8;
  localparam logic [3:0] OP_OUT = 4'h9;
  localparam logic [3:0] OP_HLT = 4'hF;

  localparam int unsigned WAIT_CNT_W = 8;

  // ALU operation applied while the operand access is in flight; LDA passes data through.
  function automatic alu_op_t alu_op_for(input logic [3:0] opcode);
    alu_op_t op_s;
    case (opcode)
      OP_ADD:  op_s = ALU_ADD;
      OP_SUB:  op_s = ALU_SUB;
      OP_AND:  op_s = ALU_AND;
      OP_OR:   op_s = ALU_OR;
      default: op_s = ALU_PASS;
    endcase
    return op_s;
  endfunction

  function automatic logic is_mem_op(input logic [3:0] opcode);
    logic mem_s;
    case (opcode)
      OP_LDA, OP_STA, OP_ADD, OP_SUB, OP_AND, OP_OR: mem_s = 1'b1;
      default:                                       mem_s = 1'b0;
    endcase
    return mem_s;
  endfunction

endpackage

// File: rtl/proc_ctrl_fsm_if.sv
// Control bundle between the sequencer (master) and the datapath/memory side
// (slave): instruction/status inputs, memory handshake and datapath strobes.
interface proc_ctrl_fsm_if;
  import proc_ctrl_pkg::*;

  logic       start;
  logic [3:0] ir_opcode;
  logic       acc_zero;
  logic       mem_ack;

  logic       mem_req;
  logic       mem_we;
  logic       mem_sel;
  logic       ir_load;
  logic       pc_inc;
  logic       pc_load;
  logic       acc_load;
  logic       out_load;
  logic [2:0] alu_op;
  logic       halted;
  logic       err;
  logic [2:0] state;

  modport master (
    input  start, ir_opcode, acc_zero, mem_ack,
    output mem_req, mem_we, mem_sel, ir_load, pc_inc, pc_load,
           acc_load, out_load, alu_op, halted, err, state
  );

  modport slave (
    output start, ir_opcode, acc_zero, mem_ack,
    input  mem_req, mem_we, mem_sel, ir_load, pc_inc, pc_load,
           acc_load, out_load, alu_op, halted, err, state
  );
endinterface

// File: rtl/proc_wait_timer.sv
// Memory wait-cycle counter. expired flags the wait cycle whose increment
// would bring the count to WAIT_MAX, so the controller can time out next edge.
module proc_wait_timer
  import proc_ctrl_pkg::*;
#(
  parameter int unsigned WAIT_MAX = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic count_en,
  output logic expired
);

  localparam logic [WAIT_CNT_W-1:0] LAST_WAIT = WAIT_CNT_W'(WAIT_MAX - 1);

  logic [WAIT_CNT_W-1:0] count_r;

  // Wait-cycle count; cleared whenever the controller is not stalled on memory.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r <= '0;
    end else if (clear) begin
      count_r <= '0;
    end else if (count_en) begin
      count_r <= count_r + 8'd1;
    end else begin
      count_r <= count_r;
    end
  end

  assign expired = count_en && (count_r == LAST_WAIT);

endmodule

// File: rtl/proc_ctrl_fsm.sv
// Instruction sequencer for the accumulator processor: fetch/decode/operand
// access with a memory wait timeout that parks the core in HALT with err set.
module proc_ctrl_fsm
  import proc_ctrl_pkg::*;
#(
  parameter int unsigned WAIT_MAX = 15
) (
  input logic            clk,
  input logic            rst,
  proc_ctrl_fsm_if.master bus
);

  state_t  state_r;
  state_t  next_state_s;
  logic    err_r;
  logic    halted_r;
  logic    wait_cycle_s;
  logic    expired_s;

  logic    mem_req_s;
  logic    mem_we_s;
  logic    mem_sel_s;
  logic    ir_load_s;
  logic    pc_inc_s;
  logic    pc_load_s;
  logic    acc_load_s;
  logic    out_load_s;
  alu_op_t alu_op_s;

  // A wait cycle is a FETCH/MEM cycle without ack; reset suppresses counting.
  assign wait_cycle_s = ((state_r == ST_FETCH) || (state_r == ST_MEM)) &&
                        !bus.mem_ack && !rst;

  proc_wait_timer #(
    .WAIT_MAX (WAIT_MAX)
  ) u_wait_timer (
    .clk      (clk),
    .rst      (rst),
    .clear    (!wait_cycle_s),
    .count_en (wait_cycle_s),
    .expired  (expired_s)
  );

  // Next-state decode; ack is checked before expiry so a late ack still completes.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.start) next_state_s = ST_FETCH;
        else           next_state_s = ST_IDLE;
      end
      ST_FETCH: begin
        if (bus.mem_ack)    next_state_s = ST_DECODE;
        else if (expired_s) next_state_s = ST_HALT;
        else                next_state_s = ST_FETCH;
      end
      ST_DECODE: begin
        if (is_mem_op(bus.ir_opcode))      next_state_s = ST_MEM;
        else if (bus.ir_opcode == OP_HLT)  next_state_s = ST_HALT;
        else                               next_state_s = ST_FETCH;
      end
      ST_MEM: begin
        if (bus.mem_ack)    next_state_s = ST_FETCH;
        else if (expired_s) next_state_s = ST_HALT;
        else                next_state_s = ST_MEM;
      end
      ST_HALT: begin
        if (bus.start && !err_r) next_state_s = ST_FETCH;
        else                     next_state_s = ST_HALT;
      end
      default: next_state_s = ST_IDLE;
    endcase
  end

  // State, sticky timeout flag and halted indication.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= ST_IDLE;
      err_r    <= 1'b0;
      halted_r <= 1'b0;
    end else begin
      state_r  <= next_state_s;
      err_r    <= err_r | expired_s;
      halted_r <= (next_state_s == ST_HALT);
    end
  end

  // Datapath strobes decoded from current state and inputs; reset forces them low.
  always_comb begin
    mem_req_s  = 1'b0;
    mem_we_s   = 1'b0;
    mem_sel_s  = 1'b0;
    ir_load_s  = 1'b0;
    pc_inc_s   = 1'b0;
    pc_load_s  = 1'b0;
    acc_load_s = 1'b0;
    out_load_s = 1'b0;
    alu_op_s   = ALU_PASS;
    if (rst) begin
      mem_req_s = 1'b0;
    end else begin
      case (state_r)
        ST_FETCH: begin
          mem_req_s = 1'b1;
          ir_load_s = bus.mem_ack;
          pc_inc_s  = bus.mem_ack;
        end
        ST_DECODE: begin
          case (bus.ir_opcode)
            OP_JMP:  pc_load_s  = 1'b1;
            OP_JZ:   pc_load_s  = bus.acc_zero;
            OP_OUT:  out_load_s = 1'b1;
            default: out_load_s = 1'b0;
          endcase
        end
        ST_MEM: begin
          mem_req_s  = 1'b1;
          mem_sel_s  = 1'b1;
          mem_we_s   = (bus.ir_opcode == OP_STA);
          alu_op_s   = alu_op_for(bus.ir_opcode);
          acc_load_s = bus.mem_ack && (bus.ir_opcode != OP_STA);
        end
        default: mem_req_s = 1'b0;
      endcase
    end
  end

  assign bus.mem_req  = mem_req_s;
  assign bus.mem_we   = mem_we_s;
  assign bus.mem_sel  = mem_sel_s;
  assign bus.ir_load  = ir_load_s;
  assign bus.pc_inc   = pc_inc_s;
  assign bus.pc_load  = pc_load_s;
  assign bus.acc_load = acc_load_s;
  assign bus.out_load = out_load_s;
  assign bus.alu_op   = alu_op_s;
  assign bus.halted   = halted_r;
  assign bus.err      = err_r;
  assign bus.state    = state_r;

endmodule

// File: tb/tb_proc_ctrl_fsm.sv
// Directed bench for proc_ctrl_fsm: the driver queues the hand-computed
// per-cycle outputs, a negedge monitor pops and compares them.
module tb_proc_ctrl_fsm;

  localparam logic [2:0] S_I = 3'd0;
  localparam logic [2:0] S_F = 3'd1;
  localparam logic [2:0] S_D = 3'd2;
  localparam logic [2:0] S_M = 3'd3;
  localparam logic [2:0] S_H = 3'd4;

  // Strobe vector: {mem_req, mem_we, mem_sel, ir_load, pc_inc, pc_load, acc_load, out_load}
  localparam logic [7:0] NONE  = 8'h00;
  localparam logic [7:0] MREQ  = 8'h80;
  localparam logic [7:0] F_ACK = 8'h98;
  localparam logic [7:0] MRD   = 8'hA0;
  localparam logic [7:0] M_ACL = 8'hA2;
  localparam logic [7:0] STA_S = 8'hE0;
  localparam logic [7:0] PCL   = 8'h04;
  localparam logic [7:0] OUTL  = 8'h01;

  typedef struct {
    string       name;
    logic [15:0] vec;
  } exp_t;

  logic clk;
  logic rst;
  exp_t exp_q[$];
  int   n_checks;
  int   n_pass;

  proc_ctrl_fsm_if bus_if();

  proc_ctrl_fsm #(
    .WAIT_MAX (15)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input string nm, input logic r, input logic s,
                      input logic [3:0] op, input logic az, input logic ack,
                      input logic [2:0] st, input logic [7:0] strb,
                      input logic [2:0] alu, input logic h, input logic e);
    exp_t x;
    @(posedge clk);
    #1;
    rst                = r;
    bus_if.start       = s;
    bus_if.ir_opcode   = op;
    bus_if.acc_zero    = az;
    bus_if.mem_ack     = ack;
    x.name = nm;
    x.vec  = {st, strb, alu, h, e};
    exp_q.push_back(x);
  endtask

  task automatic alu_instr(input string nm, input logic [3:0] op, input logic [2:0] alu);
    step({nm, "_fetch"},  1'b0, 1'b0, op, 1'b0, 1'b1, S_F, F_ACK, 3'd0, 1'b0, 1'b0);
    step({nm, "_decode"}, 1'b0, 1'b0, op, 1'b0, 1'b0, S_D, NONE,  3'd0, 1'b0, 1'b0);
    step({nm, "_mem"},    1'b0, 1'b0, op, 1'b0, 1'b1, S_M, M_ACL, alu,  1'b0, 1'b0);
  endtask

  // Monitor: compare every cycle that has a queued expectation.
  initial begin
    exp_t        e;
    logic [15:0] act;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        act = {bus_if.state, bus_if.mem_req, bus_if.mem_we, bus_if.mem_sel,
               bus_if.ir_load, bus_if.pc_inc, bus_if.pc_load, bus_if.acc_load,
               bus_if.out_load, bus_if.alu_op, bus_if.halted, bus_if.err};
        n_checks++;
        if (act === e.vec) begin
          n_pass++;
        end else begin
          $display("FAIL %s: got st=%0d strb=%b alu=%0d h=%b e=%b, want st=%0d strb=%b alu=%0d h=%b e=%b",
                   e.name, act[15:13], act[12:5], act[4:2], act[1], act[0],
                   e.vec[15:13], e.vec[12:5], e.vec[4:2], e.vec[1], e.vec[0]);
        end
      end
    end
  end

  initial begin
    n_checks           = 0;
    n_pass             = 0;
    rst                = 1'b1;
    bus_if.start       = 1'b0;
    bus_if.ir_opcode   = 4'h0;
    bus_if.acc_zero    = 1'b0;
    bus_if.mem_ack     = 1'b0;

    // Reset, start, ADD with immediate acks
    step("rst",        1'b1, 1'b0, 4'h0, 1'b0, 1'b0, S_I, NONE,  3'd0, 1'b0, 1'b0);
    step("idle_start", 1'b0, 1'b1, 4'h0, 1'b0, 1'b0, S_I, NONE,  3'd0, 1'b0, 1'b0);
    alu_instr("add", 4'h3, 3'd1);

    // JZ taken then not taken
    step("jz_fwait",   1'b0, 1'b0, 4'h8, 1'b1, 1'b0, S_F, MREQ,  3'd0, 1'b0, 1'b0);
    step("jz1_fetch",  1'b0, 1'b0, 4'h8, 1'b1, 1'b1, S_F, F_ACK, 3'd0, 1'b0, 1'b0);
    step("jz1_decode", 1'b0, 1'b0, 4'h8, 1'b1, 1'b0, S_D, PCL,   3'd0, 1'b0, 1'b0);
    step("jz0_fetch",  1'b0, 1'b0, 4'h8, 1'b0, 1'b1, S_F, F_ACK, 3'd0, 1'b0, 1'b0);
    step("jz0_decode", 1'b0, 1'b0, 4'h8, 1'b0, 1'b0, S_D, NONE,  3'd0, 1'b0, 1'b0);

    // STA with three wait cycles
    step("sta_fetch",  1'b0, 1'b0, 4'h2, 1'b0, 1'b1, S_F, F_ACK, 3'd0, 1'b0, 1'b0);
    step("sta_decode", 1'b0, 1'b0, 4'h2, 1'b0, 1'b0, S_D, NONE,  3'd0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++)
      step("sta_wait", 1'b0, 1'b0, 4'h2, 1'b0, 1'b0, S_M, STA_S, 3'd0, 1'b0, 1'b0);
    step("sta_ack",    1'b0, 1'b0, 4'h2, 1'b0, 1'b1, S_M, STA_S, 3'd0, 1'b0, 1'b0);

    // OUT, undefined opcode (start/ack ignored in DECODE), JMP
    step("out_fetch",  1'b0, 1'b0, 4'h9, 1'b0, 1'b1, S_F, F_ACK, 3'd0, 1'b0, 1'b0);
    step("out_decode", 1'b0, 1'b0, 4'h9, 1'b0, 1'b0, S_D, OUTL,  3'd0, 1'b0, 1'b0);
    step("undef_fetch",  1'b0, 1'b0, 4'hB, 1'b0, 1'b1, S_F, F_ACK, 3'd0, 1'b0, 1'b0);
    step("undef_decode", 1'b0, 1'b1, 4'hB, 1'b0, 1'b1, S_D, NONE,  3'd0, 1'b0, 1'b0);
    step("jmp_fetch",  1'b0, 1'b0, 4'h7, 1'b0, 1'b1, S_F, F_ACK, 3'd0, 1'b0, 1'b0);
    step("jmp_decode", 1'b0, 1'b0, 4'h7, 1'b0, 1'b0, S_D, PCL,   3'd0, 1'b0, 1'b0);

    // Remaining ALU ops and LDA with a wait cycle
    alu_instr("sub", 4'h4, 3'd2);
    alu_instr("and", 4'h5, 3'd3);
    alu_instr("or",  4'h6, 3'd4);
    step("lda_fetch",  1'b0, 1'b0, 4'h1, 1'b0, 1'b1, S_F, F_ACK, 3'd0, 1'b0, 1'b0);
    step("lda_decode", 1'b0, 1'b0, 4'h1, 1'b0, 1'b0, S_D, NONE,  3'd0, 1'b0, 1'b0);
    step("lda_wait",   1'b0, 1'b0, 4'h1, 1'b0, 1'b0, S_M, MRD,   3'd0, 1'b0, 1'b0);
    step("lda_ack",    1'b0, 1'b0, 4'h1, 1'b0, 1'b1, S_M, M_ACL, 3'd0, 1'b0, 1'b0);

    // HLT, then resume with start
    step("hlt_fetch",  1'b0, 1'b0, 4'hF, 1'b0, 1'b1, S_F, F_ACK, 3'd0, 1'b0, 1'b0);
    step("hlt_decode", 1'b0, 1'b0, 4'hF, 1'b0, 1'b0, S_D, NONE,  3'd0, 1'b0, 1'b0);
    step("halt",       1'b0, 1'b0, 4'h0, 1'b0, 1'b0, S_H, NONE,  3'd0, 1'b1, 1'b0);
    step("halt_ack",   1'b0, 1'b0, 4'h0, 1'b0, 1'b1, S_H, NONE,  3'd0, 1'b1, 1'b0);
    step("halt_start", 1'b0, 1'b1, 4'h0, 1'b0, 1'b0, S_H, NONE,  3'd0, 1'b1, 1'b0);
    step("resume",     1'b0, 1'b0, 4'h0, 1'b0, 1'b0, S_F, MREQ,  3'd0, 1'b0, 1'b0);
    step("nop_fetch",  1'b0, 1'b0, 4'h0, 1'b0, 1'b1, S_F, F_ACK, 3'd0, 1'b0, 1'b0);
    step("nop_decode", 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, S_D, NONE,  3'd0, 1'b0, 1'b0);

    // Fetch timeout after 15 wait cycles; start ignored while err; rst clears
    for (int i = 0; i < 15; i++)
      step("to_wait",  1'b0, 1'b0, 4'h0, 1'b0, 1'b0, S_F, MREQ,  3'd0, 1'b0, 1'b0);
    step("to_halt",    1'b0, 1'b1, 4'h0, 1'b0, 1'b0, S_H, NONE,  3'd0, 1'b1, 1'b1);
    step("to_start",   1'b0, 1'b1, 4'h0, 1'b0, 1'b0, S_H, NONE,  3'd0, 1'b1, 1'b1);
    step("to_rst",     1'b1, 1'b1, 4'h0, 1'b0, 1'b1, S_H, NONE,  3'd0, 1'b1, 1'b1);
    step("post_rst",   1'b0, 1'b0, 4'h0, 1'b0, 0,    S_I, NONE,  3'd0, 1'b0, 1'b0);

    // Ack on the last allowed wait cycle completes the access
    step("aw_start",   1'b0, 1'b1, 4'h3, 1'b0, 1'b0, S_I, NONE,  3'd0, 1'b0, 1'b0);
    for (int i = 0; i < 14; i++)
      step("aw_wait",  1'b0, 1'b0, 4'h3, 1'b0, 1'b0, S_F, MREQ,  3'd0, 1'b0, 1'b0);
    step("aw_ack",     1'b0, 1'b0, 4'h3, 1'b0, 1'b1, S_F, F_ACK, 3'd0, 1'b0, 1'b0);
    step("aw_decode",  1'b0, 1'b0, 4'h3, 1'b0, 1'b0, S_D, NONE,  3'd0, 1'b0, 1'b0);

    // Reset during an operand wait; the late ack is ignored
    step("rm_wait",     1'b0, 1'b0, 4'h3, 1'b0, 1'b0, S_M, MRD,  3'd1, 1'b0, 1'b0);
    step("rm_rst",      1'b1, 1'b0, 4'h3, 1'b0, 1'b0, S_M, NONE, 3'd0, 1'b0, 1'b0);
    step("rm_late_ack", 1'b0, 1'b0, 4'h3, 1'b0, 1'b1, S_I, NONE, 3'd0, 1'b0, 1'b0);
    step("rm_idle",     1'b0, 1'b0, 4'h3, 1'b0, 1'b1, S_I, NONE, 3'd0, 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_checks++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/proc_ctrl_fsm.md
PROC_CTRL_FSM -- requirements
Module: proc_ctrl_fsm

Interface
REQ-001 Parameter WAIT_MAX, default 15, SHALL set the max cycles a memory access may wait for mem_ack before timeout (legal 1..255).
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 start  input  1  leaves IDLE/HALT to begin fetching.
REQ-005 ir_opcode  input  4  opcode field of the instruction register.
REQ-006 acc_zero  input  1  accumulator == 0 flag.
REQ-007 mem_ack  input  1  memory access complete this cycle.
REQ-008 mem_req  output  1  memory access request.
REQ-009 mem_we  output  1  write strobe, qualified by mem_req.
REQ-010 mem_sel  output  1  address source: 0 = PC, 1 = IR operand.
REQ-011 ir_load, pc_inc, pc_load, acc_load, out_load  output  1 each  single-cycle datapath strobes.
REQ-012 alu_op  output  3  0 PASS, 1 ADD, 2 SUB, 3 AND, 4 OR.
REQ-013 halted  output  1  core stopped; err  output  1  sticky memory-timeout flag; state  output  3  debug state encoding.

Function
REQ-014 States SHALL be IDLE, FETCH, DECODE, MEM, HALT; strobes SHALL be combinational decodes of state, ir_opcode, acc_zero, mem_ack.
REQ-015 IDLE: all strobes 0; start=1 -> FETCH next cycle.
REQ-016 FETCH: mem_req=1, mem_sel=0, mem_we=0 every cycle; in the cycle mem_ack=1, ir_load=1 and pc_inc=1, next DECODE.
REQ-017 DECODE lasts exactly one cycle: NOP(0x0) and undefined 0xA-0xE -> FETCH; LDA 0x1, STA 0x2, ADD 0x3, SUB 0x4, AND 0x5, OR 0x6 -> MEM; JMP 0x7 -> pc_load=1, FETCH; JZ 0x8 -> pc_load=acc_zero, FETCH; OUT 0x9 -> out_load=1, FETCH; HLT 0xF -> HALT.
REQ-018 MEM: mem_req=1, mem_sel=1, mem_we=1 only for STA; alu_op per opcode (LDA=PASS) held all MEM cycles; in the cycle mem_ack=1, acc_load=1 for all but STA, next FETCH.
REQ-019 alu_op SHALL be 0 outside MEM.
REQ-020 Zero-wait latency: NOP/JMP/JZ/OUT/HLT 2 cycles, LDA/STA/ALU 3 cycles, each wait cycle adding 1.
REQ-021 Wait counter SHALL clear on entry to FETCH or MEM, increment each cycle mem_ack=0 there; if it reaches WAIT_MAX without ack -> HALT with err=1 next cycle.
REQ-022 HALT: halted=1, all strobes 0; start=1 with err=0 -> FETCH (PC unchanged); start ignored while err=1.
REQ-023 mem_ack SHALL be ignored outside FETCH/MEM; start SHALL be ignored in FETCH/DECODE/MEM.
REQ-024 mem_ack=1 in the same cycle as the counter reaching WAIT_MAX SHALL complete the access (ack wins, no timeout).

Reset
REQ-025 rst=1 SHALL force all strobes, mem_req, alu_op to 0 combinationally in that cycle and load IDLE, counter=0, err=0, halted=0 at the edge.
REQ-026 rst SHALL take priority over start, mem_ack, and timeout, including mid-access.

Structure
REQ-027 Package proc_ctrl_pkg SHALL hold opcode constants, state encoding, alu_op encoding; the processor datapath SHALL import the same package.
REQ-028 One sub-module, proc_wait_timer (clear, count enable, WAIT_MAX parameter, expired output), SHALL implement the timeout counter.

Verification
REQ-029 rst 2 cycles, start pulse, ack immediate, opcode 0x3 -> ir_load+pc_inc cycle 1, DECODE cycle 2, MEM cycle 3 with alu_op=1, acc_load=1, back in FETCH cycle 4.
REQ-030 opcode 0x8 with acc_zero=1 then 0 -> pc_load=1 in first DECODE, 0 in second; neither enters MEM.
REQ-031 STA, mem_ack held low 3 cycles -> mem_req=mem_we=mem_sel=1 for 4 cycles, no acc_load, FETCH after ack.
REQ-032 FETCH with mem_ack never high, WAIT_MAX=15 -> HALT, err=1, halted=1 after 15 wait cycles; start then ignored; rst clears err.
REQ-033 HLT 0xF then start -> halted=1 until start, then FETCH with mem_sel=0; opcode 0xB behaves as NOP.
REQ-034 rst asserted during MEM wait -> mem_req drops same cycle, state=IDLE next cycle, late mem_ack ignored.
